alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
Shares one combinational ALU between two requesters: port 0 is the integer execute path and port 1 is the address/branch-compare path. The block arbitrates round-robin, drives the ALU operand and select inputs, and registers the ALU result together with the winner's id and tag. The registered result is returned through a valid/ready response channel. The block sits between the decode/issue logic and the ALU instance that takes a 4-bit ALUsel.

Parameters:
XLEN, 32, operand and result width
TAGW, 4, width of the opaque tag carried from request to response

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous flush; kills any pending response
req_valid  in  2  per-requester request valid, bit i = requester i
req_ready  out  2  per-requester accept; a transfer occurs when valid&ready
req0_a, req0_b  in  XLEN each  requester 0 operands
req0_sel  in  4  requester 0 ALUsel code
req0_tag  in  TAGW  requester 0 tag
req1_a, req1_b  in  XLEN each  requester 1 operands
req1_sel  in  4  requester 1 ALUsel code
req1_tag  in  TAGW  requester 1 tag
alu_a, alu_b  out  XLEN each  operands to the shared ALU
alu_sel  out  4  ALUsel to the shared ALU
alu_r  in  XLEN  combinational ALU result
rsp_valid  out  1  response register holds a result
rsp_ready  in  1  consumer accepts the response
rsp_id  out  1  requester that owns the response
rsp_tag  out  TAGW  tag of the owning request
rsp_data  out  XLEN  registered ALU result

Behaviour:
- Reset (async, rst=1): rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_data=0. The last-grant pointer is set to 1, so requester 0 wins the first contention.
- Slot free: free = !rsp_valid | rsp_ready. Draining and refilling in the same cycle is allowed, giving a sustained throughput of one op per cycle.
- Grant, computed combinationally:
  - If flush=1 or free=0, there is no grant.
  - Otherwise, if exactly one req_valid bit is set, that requester wins.
  - If both are set, the requester that is not the last-grant pointer wins.
- req_ready[i] = grant[i]. req_ready never depends on req_valid of the same port beyond this arbitration.
- ALU drive:
  - With a grant, alu_a/alu_b/alu_sel are the winner's fields.
  - With no grant, they are driven to 0/0/4'b0000 (ADD), which keeps ALU inputs quiet.
- Latency: a request accepted in cycle N appears at rsp_valid/rsp_data/rsp_tag/rsp_id at the start of cycle N+1. The captured rsp_data is alu_r in cycle N.
- Response register update priority, highest first:
  1. flush: rsp_valid<=0.
  2. Grant: load data, id and tag; rsp_valid<=1.
  3. rsp_ready & rsp_valid: rsp_valid<=0.
  4. Otherwise hold.
- rsp_data, rsp_tag and rsp_id are stable while rsp_valid=1 and rsp_ready=0.
- Pointer: the last-grant pointer updates to the winner on every grant and is unchanged when there is no grant.
- Flush:
  - Discards a held response.
  - Blocks acceptance in the same cycle; requesters see req_ready=0 and must hold or drop per their own flush rules.
  - Does not alter the pointer.
- Reset mid-operation: any in-flight response is lost, with no partial outputs.
- Unknown alu_sel codes are passed through unchanged. The arbiter does not decode ops.
- Starvation bound: a continuously valid requester is granted within 2 free cycles.

Decomposition:
- Shared package alu_pkg holds:
  - ALUsel constants: ADD 0000, SUB 0001, OR 0100, AND 0101, XOR 0111, SLL 1000, SRL 1001, SRA 1011, SLT 1101, SLTU 1111.
  - XLEN default.
  - The request field bundle typedef (a, b, sel, tag).
- One sub-module, rr_arb2: 2-way round-robin arbiter with inputs req[1:0], en, and pointer state, and output gnt[1:0]. It is instantiated once.
- The ALU itself stays external. The bench uses a reference ALU model.

Test Plan:
1. Reset, then a single request: req0 a=5, b=3, sel=SUB, tag=2, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=2, rsp_id=0, rsp_tag=2.
2. Contention: both valid continuously for 4 cycles with rsp_ready=1 -> grants 0,1,0,1. rsp_id follows the same order one cycle later.
3. Backpressure: response held with rsp_ready=0 for 3 cycles while req1 is valid -> req_ready=0 and rsp_data stable. When rsp_ready rises, req1 is accepted the same cycle and its result appears the next cycle.
4. Back-to-back throughput: req0 issues ADD 1+1, XOR F0^0F, SLL 1<<4 on consecutive cycles with rsp_ready=1 -> responses 2, FF, 10 on consecutive cycles with no bubbles.
5. Flush while a response is held and req0 is valid -> rsp_valid=0 next cycle, req0 not accepted during the flush cycle, pointer unchanged. req0 is accepted the cycle after.
6. Async reset asserted mid-cycle with rsp_valid=1 -> all outputs 0 immediately. After release, under contention requester 0 is granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing arbiter: ALUsel codes, default
// widths and the per-requester field bundle.
package alu_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned TAGW_DEF = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_OR   = 4'b0100,
    ALU_AND  = 4'b0101,
    ALU_XOR  = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1011,
    ALU_SLT  = 4'b1101,
    ALU_SLTU = 4'b1111
  } alu_sel_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0] a;
    logic [XLEN_DEF-1:0] b;
    logic [3:0]          sel;
    logic [TAGW_DEF-1:0] tag;
  } alu_req_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request, ALU-drive and response signals of the ALU-sharing arbiter.
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned TAGW = TAGW_DEF
);

  logic            flush;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic [3:0]      req0_sel;
  logic [TAGW-1:0] req0_tag;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic [3:0]      req1_sel;
  logic [TAGW-1:0] req1_tag;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_sel;
  logic [XLEN-1:0] alu_r;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [TAGW-1:0] rsp_tag;
  logic [XLEN-1:0] rsp_data;

  // Environment side: requesters, response consumer and the ALU itself.
  modport master (
    output flush, req_valid, req0_a, req0_b, req0_sel, req0_tag,
           req1_a, req1_b, req1_sel, req1_tag, alu_r, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_tag,
           rsp_data
  );

  // Arbiter side.
  modport slave (
    input  flush, req_valid, req0_a, req0_b, req0_sel, req0_tag,
           req1_a, req1_b, req1_sel, req1_tag, alu_r, rsp_ready,
    output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_tag,
           rsp_data
  );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. i_ptr is the last requester granted; under
// contention the other requester wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_en,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  // One-hot grant, or none when disabled or idle.
  always_comb begin
    o_gnt = '0;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = i_ptr ? 2'b01 : 2'b10;
        default: o_gnt = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between the execute path (port 0)
// and the address/branch-compare path (port 1). Winner's operands drive the
// ALU; the result, id and tag are captured into a one-entry response slot.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned TAGW = TAGW_DEF
) (
  input logic               clk,
  input logic               rst,
  alu_share_arbiter_if.slave bus
);

  logic            r_ptr;
  logic            r_rsp_valid;
  logic            r_rsp_id;
  logic [TAGW-1:0] r_rsp_tag;
  logic [XLEN-1:0] r_rsp_data;

  logic            w_free;
  logic            w_en;
  logic [1:0]      w_gnt;
  alu_req_t        w_req0;
  alu_req_t        w_req1;
  alu_req_t        w_win;

  // Slot can take a new result if empty or being drained this cycle.
  assign w_free = !r_rsp_valid || bus.rsp_ready;
  assign w_en   = !bus.flush && w_free;

  rr_arb2 u_arb (
    .i_req (bus.req_valid),
    .i_en  (w_en),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  assign bus.req_ready = w_gnt;

  // Bundle each requester's fields.
  always_comb begin
    w_req0     = '0;
    w_req0.a   = bus.req0_a;
    w_req0.b   = bus.req0_b;
    w_req0.sel = bus.req0_sel;
    w_req0.tag = bus.req0_tag;
    w_req1     = '0;
    w_req1.a   = bus.req1_a;
    w_req1.b   = bus.req1_b;
    w_req1.sel = bus.req1_sel;
    w_req1.tag = bus.req1_tag;
  end

  // Winner mux; zero (ADD 0+0) when nobody is granted keeps the ALU quiet.
  always_comb begin
    w_win = '0;
    if (w_gnt[0])      w_win = w_req0;
    else if (w_gnt[1]) w_win = w_req1;
  end

  assign bus.alu_a   = w_win.a;
  assign bus.alu_b   = w_win.b;
  assign bus.alu_sel = w_win.sel;

  // Response slot: flush beats a new grant, which beats a plain drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_tag   <= '0;
      r_rsp_data  <= '0;
    end else if (bus.flush) begin
      r_rsp_valid <= 1'b0;
    end else if (|w_gnt) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gnt[1];
      r_rsp_tag   <= w_win.tag;
      r_rsp_data  <= bus.alu_r;
    end else if (bus.rsp_ready && r_rsp_valid) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Last-grant pointer; reset to 1 so requester 0 wins first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b1;
    end else if (w_gnt[0]) begin
      r_ptr <= 1'b0;
    end else if (w_gnt[1]) begin
      r_ptr <= 1'b1;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_tag   = r_rsp_tag;
  assign bus.rsp_data  = r_rsp_data;

endmodule
